// File: rtl/vector_row_loader.sv
// Serial element loader for an addressable double buffer: fills the inactive row,
// zero-pads short rows, then requests a buffer swap once the active row is released.
module vector_row_loader #(
   parameter int  DATA_WIDTH  = 8,
   parameter int  MATRIX_SIZE = 3,
   parameter int  CNT_WIDTH   = 16,
   localparam int AW          = $clog2(MATRIX_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_last,
   input  logic                  consume_ready,
   output logic [AW-1:0]         load_addr,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic                  load_we,
   output logic                  swap_buffers,
   output logic                  active_valid,
   output logic [CNT_WIDTH-1:0]  row_count
);

   typedef enum logic [1:0] {
      ST_FILL = 2'b00,
      ST_PAD  = 2'b01,
      ST_WAIT = 2'b10
   } state_t;

   localparam logic [AW-1:0] LAST_IDX = AW'(MATRIX_SIZE - 1);

   state_t                 state_q, state_d;
   logic [AW-1:0]          idx_q, idx_d;
   logic                   active_valid_q, active_valid_d;
   logic [CNT_WIDTH-1:0]   row_count_q, row_count_d;

   always_comb begin
      // NOTE: every signal gets a default before the case, so no path can infer a latch.
      state_d      = state_q;
      idx_d        = idx_q;
      s_ready      = 1'b0;
      load_we      = 1'b0;
      load_addr    = idx_q;
      load_data    = '0;
      swap_buffers = 1'b0;

      unique case (state_q)
         ST_FILL: begin
            s_ready   = 1'b1;
            load_data = s_data;
            // Downstream buffer is resetting alongside us, so suppress writes under rst.
            load_we   = s_valid && !rst;
            if (s_valid) begin
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = ST_WAIT;
               end else begin
                  idx_d = idx_q + AW'(1);
                  if (s_last) state_d = ST_PAD;
               end
            end
         end
         ST_PAD: begin
            load_we = 1'b1;
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = ST_WAIT;
            end else begin
               idx_d = idx_q + AW'(1);
            end
         end
         ST_WAIT: begin
            swap_buffers = consume_ready || !active_valid_q;
            if (swap_buffers) state_d = ST_FILL;
         end
         default: begin
            state_d = ST_FILL;
            idx_d   = '0;
         end
      endcase

      if (swap_buffers)       active_valid_d = 1'b1;
      else if (consume_ready) active_valid_d = 1'b0;
      else                    active_valid_d = active_valid_q;

      row_count_d = swap_buffers ? row_count_q + CNT_WIDTH'(1) : row_count_q;
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_FILL;
         idx_q          <= '0;
         active_valid_q <= 1'b0;
         row_count_q    <= '0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         active_valid_q <= active_valid_d;
         row_count_q    <= row_count_d;
      end
   end

   assign active_valid = active_valid_q;
   assign row_count    = row_count_q;

endmodule

// File: tb/tb_vector_row_loader.sv
// Directed bench for vector_row_loader (DATA_WIDTH=8, MATRIX_SIZE=3): inputs change
// and outputs are sampled in the low phase of clk, away from the rising edge.
module tb_vector_row_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  s_data;
   logic        s_last;
   logic        consume_ready;
   logic [1:0]  load_addr;
   logic [7:0]  load_data;
   logic        load_we;
   logic        swap_buffers;
   logic        active_valid;
   logic [15:0] row_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vector_row_loader #(
      .DATA_WIDTH (8),
      .MATRIX_SIZE(3),
      .CNT_WIDTH  (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .s_last       (s_last),
      .consume_ready(consume_ready),
      .load_addr    (load_addr),
      .load_data    (load_data),
      .load_we      (load_we),
      .swap_buffers (swap_buffers),
      .active_valid (active_valid),
      .row_count    (row_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to the next low phase, apply inputs, let combinational outputs settle.
   task automatic step(input logic v, input logic [7:0] d, input logic l, input logic cr);
      @(negedge clk);
      s_valid       = v;
      s_data        = d;
      s_last        = l;
      consume_ready = cr;
      #1;
   endtask

   task automatic check_write(input string tag, input logic [1:0] addr, input logic [7:0] data);
      check({tag, "_we"}, load_we, 1'b1);
      check({tag, "_addr"}, load_addr, addr);
      check({tag, "_data"}, load_data, data);
   endtask

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; consume_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_s_ready", s_ready, 1'b1);
      check("rst_we", load_we, 1'b0);
      check("rst_addr", load_addr, 2'd0);
      check("rst_data", load_data, 8'h00);
      check("rst_swap", swap_buffers, 1'b0);
      check("rst_active", active_valid, 1'b0);
      check("rst_rows", row_count, 16'd0);
      @(negedge clk);
      rst = 1'b0;

      // Full row, back-to-back; first row swaps as soon as WAIT is reached
      step(1, 8'h11, 0, 0); check_write("r1_e0", 2'd0, 8'h11);
      step(1, 8'h22, 0, 0); check_write("r1_e1", 2'd1, 8'h22);
      step(1, 8'h33, 1, 0); check_write("r1_e2", 2'd2, 8'h33);
      step(0, 8'h00, 0, 0);
      check("r1_wait_ready", s_ready, 1'b0);
      check("r1_wait_we", load_we, 1'b0);
      check("r1_swap", swap_buffers, 1'b1);
      step(0, 8'h00, 0, 0);
      check("r1_swap_done", swap_buffers, 1'b0);
      check("r1_active", active_valid, 1'b1);
      check("r1_rows", row_count, 16'd1);
      check("r1_ready_again", s_ready, 1'b1);

      // Short row: one element then two zero pads
      step(1, 8'hAA, 1, 0); check_write("short_e0", 2'd0, 8'hAA);
      step(0, 8'h00, 0, 0);
      check("pad1_ready", s_ready, 1'b0);
      check_write("pad1", 2'd1, 8'h00);
      step(0, 8'h00, 0, 0);
      check("pad2_ready", s_ready, 1'b0);
      check_write("pad2", 2'd2, 8'h00);
      step(0, 8'h00, 0, 0);
      check("short_hold", swap_buffers, 1'b0);
      step(0, 8'h00, 0, 1);
      check("short_swap", swap_buffers, 1'b1);
      check("short_swap_we", load_we, 1'b0);
      step(0, 8'h00, 0, 0);
      check("short_rows", row_count, 16'd2);
      check("short_active", active_valid, 1'b1);

      // Backpressure: WAIT holds while the active row is still in use
      step(1, 8'h44, 0, 0); check_write("bp_e0", 2'd0, 8'h44);
      step(1, 8'h45, 0, 0); check_write("bp_e1", 2'd1, 8'h45);
      step(1, 8'h46, 0, 0); check_write("bp_e2", 2'd2, 8'h46);
      for (int i = 0; i < 10; i++) begin
         step(1, 8'h99, 0, 0);
         check("bp_hold_ready", s_ready, 1'b0);
         check("bp_hold_swap", swap_buffers, 1'b0);
         check("bp_hold_we", load_we, 1'b0);
      end
      step(0, 8'h00, 0, 1);
      check("bp_swap", swap_buffers, 1'b1);
      step(0, 8'h00, 0, 0);
      check("bp_active", active_valid, 1'b1);
      check("bp_rows", row_count, 16'd3);

      // Gaps in s_valid never advance the address
      step(1, 8'h01, 0, 0); check_write("gap_e0", 2'd0, 8'h01);
      step(0, 8'h00, 0, 0); check("gap_idle1_we", load_we, 1'b0);
      step(0, 8'h00, 0, 0); check("gap_idle2_we", load_we, 1'b0);
      check("gap_idle_ready", s_ready, 1'b1);
      step(1, 8'h02, 0, 0); check_write("gap_e1", 2'd1, 8'h02);
      step(0, 8'h00, 0, 0); check("gap_idle3_we", load_we, 1'b0);
      step(1, 8'h03, 0, 0); check_write("gap_e2", 2'd2, 8'h03);
      step(0, 8'h00, 0, 1);
      check("gap_swap", swap_buffers, 1'b1);
      step(0, 8'h00, 0, 0);
      check("gap_rows", row_count, 16'd4);

      // Release of the active row while filling: no swap, index kept
      step(1, 8'h70, 0, 0); check_write("rel_e0", 2'd0, 8'h70);
      step(0, 8'h00, 0, 1);
      check("rel_no_swap", swap_buffers, 1'b0);
      check("rel_no_we", load_we, 1'b0);
      step(0, 8'h00, 0, 0);
      check("rel_active", active_valid, 1'b0);
      check("rel_rows", row_count, 16'd4);
      step(1, 8'h71, 0, 0); check_write("rel_e1", 2'd1, 8'h71);

      // Asynchronous reset in the low phase, after two accepted elements
      @(negedge clk);
      s_valid = 1'b0; s_data = '0;
      #1;
      check("pre_rst_addr", load_addr, 2'd2);
      rst = 1'b1;
      #1;
      check("arst_addr", load_addr, 2'd0);
      check("arst_rows", row_count, 16'd0);
      check("arst_ready", s_ready, 1'b1);
      check("arst_we", load_we, 1'b0);
      check("arst_swap", swap_buffers, 1'b0);
      check("arst_active", active_valid, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      step(1, 8'h55, 0, 0); check_write("post_e0", 2'd0, 8'h55);
      check("post_rows", row_count, 16'd0);
      step(1, 8'h66, 0, 0); check_write("post_e1", 2'd1, 8'h66);
      step(1, 8'h77, 0, 0); check_write("post_e2", 2'd2, 8'h77);
      step(0, 8'h00, 0, 0);
      check("post_swap", swap_buffers, 1'b1);
      step(0, 8'h00, 0, 0);
      check("post_rows_final", row_count, 16'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
